// File: rtl/boot_supervisor_pkg.sv
// Shared types and elaboration-time helpers for the boot-window supervisor.
package boot_supervisor_pkg;

    typedef enum logic [1:0] {
        WAIT        = 2'd0,
        PROGRAMMING = 2'd1,
        RECONFIG    = 2'd2
    } state_e;

    // PROGRAMMING blinks this many times faster than WAIT.
    localparam int BLINK_PROG_MULT = 8;

    function automatic int calc_tc(input int clk_hz, input int timeout_ms);
        int tc;
        tc = (clk_hz / 1000) * timeout_ms;
        return (tc < 1) ? 1 : tc;
    endfunction

    function automatic int calc_gw(input int num_hosts);
        return (num_hosts > 1) ? $clog2(num_hosts) : 1;
    endfunction

    // Clocks between LED toggles for a given blink rate multiplier.
    function automatic int calc_blink_div(input int clk_hz, input int blink_hz, input int mult);
        int d;
        d = clk_hz / (2 * mult * blink_hz);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/boot_supervisor_if.sv
// Host/flash SPI pins plus supervisor status; slave = supervisor, master = board side.
interface boot_supervisor_if
    import boot_supervisor_pkg::*;
#(
    parameter int NUM_HOSTS = 2
);
    localparam int GW = calc_gw(NUM_HOSTS);

    logic                 boot_hold;
    logic [NUM_HOSTS-1:0] host_sck;
    logic [NUM_HOSTS-1:0] host_cs_n;
    logic [NUM_HOSTS-1:0] host_mosi;
    logic [NUM_HOSTS-1:0] host_miso;
    logic                 flash_clk;
    logic                 flash_cs_n;
    logic                 flash_mosi;
    logic                 flash_miso;
    logic [GW-1:0]        grant;
    logic                 busy;
    logic                 reconfig_n;
    logic                 led;

    modport slave (
        input  boot_hold, host_sck, host_cs_n, host_mosi, flash_miso,
        output host_miso, flash_clk, flash_cs_n, flash_mosi, grant, busy, reconfig_n, led
    );

    modport master (
        output boot_hold, host_sck, host_cs_n, host_mosi, flash_miso,
        input  host_miso, flash_clk, flash_cs_n, flash_mosi, grant, busy, reconfig_n, led
    );

endinterface

// File: rtl/cdc_sync_bus.sv
// Per-bit multi-flop synchroniser; resets to all ones so idle chip selects read as deasserted.
module cdc_sync_bus #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/boot_supervisor.sv
// Boot-window supervisor: muxes SPI hosts onto the config flash, restarts a quiet-time
// timeout on any host CS activity, and latches an active-low reconfig request when it expires.
module boot_supervisor
    import boot_supervisor_pkg::*;
#(
    parameter int CLK_HZ        = 27_000_000,
    parameter int TIMEOUT_MS    = 5000,
    parameter int NUM_HOSTS     = 2,
    parameter int SYNC_STAGES   = 2,
    parameter int BLINK_WAIT_HZ = 1
) (
    input  logic             clk,
    input  logic             rst,
    boot_supervisor_if.slave sup_if
);

    localparam int TC       = calc_tc(CLK_HZ, TIMEOUT_MS);
    localparam int CW       = $clog2(TC + 1);
    localparam int GW       = calc_gw(NUM_HOSTS);
    localparam int WAIT_DIV = calc_blink_div(CLK_HZ, BLINK_WAIT_HZ, 1);
    localparam int PROG_DIV = calc_blink_div(CLK_HZ, BLINK_WAIT_HZ, BLINK_PROG_MULT);
    localparam int BW       = $clog2(WAIT_DIV + 1);

    localparam logic [CW-1:0] TC_V      = CW'(TC);
    localparam logic [CW-1:0] TC_M1     = CW'(TC - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [BW-1:0] WAIT_M1   = BW'(WAIT_DIV - 1);
    localparam logic [BW-1:0] PROG_M1   = BW'(PROG_DIV - 1);
    localparam logic [BW-1:0] BLINK_ONE = BW'(1);

    logic [NUM_HOSTS-1:0] cs_sync;
    logic [NUM_HOSTS-1:0] cs_prev_q;
    logic [NUM_HOSTS-1:0] cs_fall;
    logic                 any_cs;
    logic                 prev_idle;

    logic [GW-1:0] grant_q, grant_d;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] blink_q, blink_d;
    logic [BW-1:0] blink_lim;
    logic          led_q, led_d;
    logic          reconfig_n_q, reconfig_n_d;
    logic [NUM_HOSTS-1:0] host_miso_w;

    cdc_sync_bus #(
        .WIDTH  (NUM_HOSTS),
        .STAGES (SYNC_STAGES)
    ) u_cs_sync (
        .clk (clk),
        .rst (rst),
        .d_i (sup_if.host_cs_n),
        .q_o (cs_sync)
    );

    assign any_cs    = |(~cs_sync);
    assign prev_idle = &cs_prev_q;
    assign cs_fall   = cs_prev_q & ~cs_sync;

    // Grant only moves when the flash was idle last cycle; lowest index wins a tie.
    always_comb begin
        grant_d = grant_q;
        if (prev_idle) begin
            for (int k = NUM_HOSTS - 1; k >= 0; k--) begin
                if (cs_fall[k]) begin
                    grant_d = GW'(k);
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        reconfig_n_d = reconfig_n_q;
        blink_d      = blink_q;
        led_d        = led_q;
        blink_lim    = (state_q == PROGRAMMING) ? PROG_M1 : WAIT_M1;

        case (state_q)
            WAIT: begin
                if (any_cs) begin
                    state_d = PROGRAMMING;
                    cnt_d   = '0;
                end else if (sup_if.boot_hold) begin
                    cnt_d = '0;
                end else if (cnt_q == TC_M1) begin
                    state_d      = RECONFIG;
                    reconfig_n_d = 1'b0;
                    cnt_d        = TC_V;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PROGRAMMING: begin
                cnt_d = '0;
                if (!any_cs) begin
                    state_d = WAIT;
                end
            end
            RECONFIG: begin
                reconfig_n_d = 1'b0;
                if (cnt_q != TC_V) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
        endcase

        // Blink phase restarts on every state change so each state shows its own rate cleanly.
        if (state_d != state_q) begin
            blink_d = '0;
        end else if (blink_q >= blink_lim) begin
            blink_d = '0;
            led_d   = ~led_q;
        end else begin
            blink_d = blink_q + BLINK_ONE;
        end
        if (state_d == RECONFIG) begin
            led_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_prev_q    <= '1;
            grant_q      <= '0;
            state_q      <= WAIT;
            cnt_q        <= '0;
            blink_q      <= '0;
            led_q        <= 1'b1;
            reconfig_n_q <= 1'b1;
        end else begin
            cs_prev_q    <= cs_sync;
            grant_q      <= grant_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            blink_q      <= blink_d;
            led_q        <= led_d;
            reconfig_n_q <= reconfig_n_d;
        end
    end

    always_comb begin
        host_miso_w          = '0;
        host_miso_w[grant_q] = sup_if.flash_miso;
    end

    assign sup_if.flash_clk  = sup_if.host_sck[grant_q];
    assign sup_if.flash_cs_n = sup_if.host_cs_n[grant_q];
    assign sup_if.flash_mosi = sup_if.host_mosi[grant_q];
    assign sup_if.host_miso  = host_miso_w;
    assign sup_if.grant      = grant_q;
    assign sup_if.busy       = (state_q == PROGRAMMING);
    assign sup_if.reconfig_n = reconfig_n_q;
    assign sup_if.led        = led_q;

endmodule

// File: tb/tb_boot_supervisor.sv
// Self-checking bench for boot_supervisor with a small timeout so every path is reachable quickly.
module tb_boot_supervisor;

    localparam int P_CLK_HZ = 1000;
    localparam int P_TO_MS  = 10;
    localparam int P_NH     = 2;
    localparam int P_SS     = 2;
    localparam int P_BLINK  = 50;

    // 1000 Hz * 10 ms; 1000/(2*50); 1000/(16*50) rounded down.
    localparam int EXP_TC       = 10;
    localparam int EXP_WAIT_DIV = 10;
    localparam int EXP_PROG_DIV = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    boot_supervisor_if #(.NUM_HOSTS(P_NH)) sif ();

    boot_supervisor #(
        .CLK_HZ        (P_CLK_HZ),
        .TIMEOUT_MS    (P_TO_MS),
        .NUM_HOSTS     (P_NH),
        .SYNC_STAGES   (P_SS),
        .BLINK_WAIT_HZ (P_BLINK)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sup_if (sif)
    );

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sif.boot_hold  = 1'b0;
        sif.host_sck   = '0;
        sif.host_cs_n  = '1;
        sif.host_mosi  = '0;
        sif.flash_miso = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic count_to_reconfig(output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (sif.reconfig_n === 1'b0) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic count_to_led_change(output int n);
        logic start;
        start = sif.led;
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (sif.led !== start) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int n, e;
        idle_inputs();
        rst = 1'b1;
        tick();
        total++; if (sif.grant !== 1'b0) begin bad++; $display("FAIL reset_grant: got %b want 0", sif.grant); end
        total++; if (sif.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", sif.busy); end
        total++; if (sif.reconfig_n !== 1'b1) begin bad++; $display("FAIL reset_reconfig_n: got %b want 1", sif.reconfig_n); end
        total++; if (sif.led !== 1'b1) begin bad++; $display("FAIL reset_led: got %b want 1", sif.led); end
        rst = 1'b0;
        exp_q.push_back(EXP_TC);
        count_to_reconfig(n);
        e = exp_q.pop_front();
        total++; if (n !== e) begin bad++; $display("FAIL idle_timeout_latency: got %0d want %0d", n, e); end
        total++; if (sif.led !== 1'b0) begin bad++; $display("FAIL reconfig_led: got %b want 0", sif.led); end
        repeat (100) tick();
        total++; if (sif.reconfig_n !== 1'b0) begin bad++; $display("FAIL reconfig_held: got %b want 0", sif.reconfig_n); end
        total++; if (sif.led !== 1'b0) begin bad++; $display("FAIL reconfig_led_held: got %b want 0", sif.led); end
    endtask

    task automatic test_host1_program();
        int n, e, w;
        logic [2:0] pat;
        do_reset();
        repeat (4) tick();
        sif.host_cs_n[1] = 1'b0;
        repeat (3) tick();
        total++; if (sif.grant !== 1'b1) begin bad++; $display("FAIL h1_grant: got %b want 1", sif.grant); end
        total++; if (sif.busy !== 1'b1) begin bad++; $display("FAIL h1_busy: got %b want 1", sif.busy); end
        for (int i = 0; i < 8; i++) begin
            pat = 3'(i);
            sif.host_sck[1]  = pat[0];
            sif.host_sck[0]  = ~pat[0];
            sif.host_mosi[1] = pat[1];
            sif.host_mosi[0] = ~pat[1];
            sif.flash_miso   = pat[2];
            #1;
            total++; if (sif.flash_clk !== pat[0]) begin bad++; $display("FAIL h1_flash_clk[%0d]: got %b want %b", i, sif.flash_clk, pat[0]); end
            total++; if (sif.flash_mosi !== pat[1]) begin bad++; $display("FAIL h1_flash_mosi[%0d]: got %b want %b", i, sif.flash_mosi, pat[1]); end
            total++; if (sif.flash_cs_n !== 1'b0) begin bad++; $display("FAIL h1_flash_cs_n[%0d]: got %b want 0", i, sif.flash_cs_n); end
            total++; if (sif.host_miso !== {pat[2], 1'b0}) begin bad++; $display("FAIL h1_host_miso[%0d]: got %b want %b", i, sif.host_miso, {pat[2], 1'b0}); end
            tick();
        end
        repeat (9) tick();
        idle_inputs();
        w = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (sif.busy === 1'b0) begin w = i; break; end
        end
        total++; if (w < 0) begin bad++; $display("FAIL h1_busy_release: got timeout want busy=0"); end
        exp_q.push_back(EXP_TC);
        count_to_reconfig(n);
        e = exp_q.pop_front();
        total++; if (n !== e) begin bad++; $display("FAIL h1_timeout_after_release: got %0d want %0d", n, e); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        tick();
        sif.host_cs_n = 2'b00;
        repeat (3) tick();
        total++; if (sif.grant !== 1'b0) begin bad++; $display("FAIL sim_grant: got %b want 0", sif.grant); end
        total++; if (sif.busy !== 1'b1) begin bad++; $display("FAIL sim_busy: got %b want 1", sif.busy); end
        sif.host_cs_n  = 2'b10;
        sif.host_sck   = 2'b10;
        sif.host_mosi  = 2'b10;
        sif.flash_miso = 1'b1;
        #1;
        total++; if (sif.flash_cs_n !== 1'b0) begin bad++; $display("FAIL sim_cs_host0: got %b want 0", sif.flash_cs_n); end
        total++; if (sif.flash_clk !== 1'b0) begin bad++; $display("FAIL sim_clk_host0: got %b want 0", sif.flash_clk); end
        total++; if (sif.flash_mosi !== 1'b0) begin bad++; $display("FAIL sim_mosi_host0: got %b want 0", sif.flash_mosi); end
        total++; if (sif.host_miso !== 2'b01) begin bad++; $display("FAIL sim_host_miso: got %b want 01", sif.host_miso); end
        tick();
        sif.host_cs_n = 2'b01;
        repeat (4) tick();
        total++; if (sif.grant !== 1'b0) begin bad++; $display("FAIL sim_grant_kept: got %b want 0", sif.grant); end
        total++; if (sif.flash_cs_n !== 1'b1) begin bad++; $display("FAIL sim_cs_mirrors_host0: got %b want 1", sif.flash_cs_n); end
        total++; if (sif.host_miso[1] !== 1'b0) begin bad++; $display("FAIL sim_miso1_blocked: got %b want 0", sif.host_miso[1]); end
        idle_inputs();
        repeat (5) tick();
    endtask

    task automatic test_boot_hold();
        int n, e;
        do_reset();
        sif.boot_hold = 1'b1;
        exp_q.push_back(EXP_WAIT_DIV);
        exp_q.push_back(EXP_WAIT_DIV);
        count_to_led_change(n);
        e = exp_q.pop_front();
        total++; if (n !== e) begin bad++; $display("FAIL hold_led_first: got %0d want %0d", n, e); end
        count_to_led_change(n);
        e = exp_q.pop_front();
        total++; if (n !== e) begin bad++; $display("FAIL hold_led_period: got %0d want %0d", n, e); end
        repeat (30) tick();
        total++; if (sif.reconfig_n !== 1'b1) begin bad++; $display("FAIL hold_no_reconfig: got %b want 1", sif.reconfig_n); end
        sif.boot_hold = 1'b0;
        exp_q.push_back(EXP_TC);
        count_to_reconfig(n);
        e = exp_q.pop_front();
        total++; if (n !== e) begin bad++; $display("FAIL hold_release_timeout: got %0d want %0d", n, e); end
        sif.boot_hold = 1'b1;
        repeat (3) tick();
        total++; if (sif.reconfig_n !== 1'b0) begin bad++; $display("FAIL hold_in_reconfig: got %b want 0", sif.reconfig_n); end
    endtask

    task automatic test_async_reset();
        do_reset();
        sif.host_cs_n[1] = 1'b0;
        repeat (3) tick();
        total++; if (sif.busy !== 1'b1) begin bad++; $display("FAIL arst_pre_busy: got %b want 1", sif.busy); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (sif.grant !== 1'b0) begin bad++; $display("FAIL arst_grant: got %b want 0", sif.grant); end
        total++; if (sif.busy !== 1'b0) begin bad++; $display("FAIL arst_busy: got %b want 0", sif.busy); end
        total++; if (sif.reconfig_n !== 1'b1) begin bad++; $display("FAIL arst_reconfig_n: got %b want 1", sif.reconfig_n); end
        total++; if (sif.flash_cs_n !== 1'b1) begin bad++; $display("FAIL arst_flash_cs_n: got %b want 1", sif.flash_cs_n); end
        tick();
        rst = 1'b0;
        idle_inputs();
        repeat (3) tick();
    endtask

    task automatic test_cs_vs_timeout();
        int n, e;
        do_reset();
        repeat (EXP_TC - 1 - P_SS) tick();
        sif.host_cs_n[0] = 1'b0;
        repeat (P_SS) tick();
        total++; if (sif.busy !== 1'b0) begin bad++; $display("FAIL race_pre_busy: got %b want 0", sif.busy); end
        tick();
        total++; if (sif.busy !== 1'b1) begin bad++; $display("FAIL race_busy: got %b want 1", sif.busy); end
        total++; if (sif.reconfig_n !== 1'b1) begin bad++; $display("FAIL race_reconfig_n: got %b want 1", sif.reconfig_n); end
        exp_q.push_back(EXP_PROG_DIV);
        exp_q.push_back(EXP_PROG_DIV);
        count_to_led_change(n);
        e = exp_q.pop_front();
        total++; if (n !== e) begin bad++; $display("FAIL race_led_first: got %0d want %0d", n, e); end
        count_to_led_change(n);
        e = exp_q.pop_front();
        total++; if (n !== e) begin bad++; $display("FAIL race_led_period: got %0d want %0d", n, e); end
        repeat (20) tick();
        total++; if (sif.reconfig_n !== 1'b1) begin bad++; $display("FAIL race_held_reconfig_n: got %b want 1", sif.reconfig_n); end
        idle_inputs();
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit reached want test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_host1_program();
        test_simultaneous();
        test_boot_hold();
        test_async_reset();
        test_cs_vs_timeout();
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_drain: got %0d want 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
